// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer: radix-2 shift-add multiply and restoring unsigned divide.
// Optional early termination of multiplies when MULDIV_EARLY_EXIT_EN is defined.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_SMUL = 3'b110;
  localparam logic [2:0] OP_UMUL = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg;
  logic [2:0]           op_reg;
  logic                 neg_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  // Multiplicand (shifted left each step) or divisor in the low half
  logic [2*WIDTH-1:0]   opa_reg;
  // Multiplier, shifted right each step so bit 0 is the current bit
  logic [WIDTH-1:0]     opb_reg;

  logic                 op_valid_in, dz_in, is_div_reg, is_smul_reg, last_iter;
  logic [2*WIDTH-1:0]   mul_add, mul_acc, div_acc, acc_step, result_next;
  logic [WIDTH:0]       trial, diff;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? ('0 - v) : v;
  endfunction

  assign op_valid_in = Op[2];
  assign dz_in       = (Op == OP_DIV) && (SrcB == '0);
  assign is_div_reg  = (op_reg == OP_DIV);
  assign is_smul_reg = (op_reg == OP_SMUL);

`ifdef MULDIV_EARLY_EXIT_EN
  // Stop once no multiplier bits above the current one remain set
  assign last_iter = (cnt_reg == LAST_CNT) ||
                     (!is_div_reg && (opb_reg[WIDTH-1:1] == '0));
`else
  assign last_iter = (cnt_reg == LAST_CNT);
`endif

  // One iteration of either datapath
  always_comb begin
    mul_add = opb_reg[0] ? opa_reg : '0;
    mul_acc = acc_reg + mul_add;
    trial   = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    diff    = trial - {1'b0, opa_reg[WIDTH-1:0]};
    if (diff[WIDTH]) begin
      div_acc = {trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
    end else begin
      div_acc = {diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
    end
    acc_step    = is_div_reg ? div_acc : mul_acc;
    result_next = (is_smul_reg && neg_reg) ? ('0 - acc_step) : acc_step;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (Start) begin
          if (!op_valid_in || dz_in) begin
            state_next = S_DONE;
          end else begin
            state_next = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (Flush) begin
          state_next = S_IDLE;
        end else if (last_iter) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    Busy = (state_reg == S_RUN);
    Done = (state_reg == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg   <= '0;
      op_reg    <= '0;
      neg_reg   <= 1'b0;
      acc_reg   <= '0;
      opa_reg   <= '0;
      opb_reg   <= '0;
      ResultLo  <= '0;
      ResultHi  <= '0;
      DivByZero <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (Start) begin
            cnt_reg   <= '0;
            DivByZero <= dz_in;
            if (dz_in) begin
              ResultLo <= '1;
              ResultHi <= SrcA;
            end else if (!op_valid_in) begin
              ResultLo <= '0;
              ResultHi <= '0;
            end else begin
              op_reg <= Op;
              if (Op == OP_DIV) begin
                acc_reg <= {{WIDTH{1'b0}}, SrcA};
                opa_reg <= {{WIDTH{1'b0}}, SrcB};
                opb_reg <= '0;
                neg_reg <= 1'b0;
              end else begin
                acc_reg <= '0;
                opa_reg <= {{WIDTH{1'b0}}, magnitude(SrcA, Op == OP_SMUL)};
                opb_reg <= magnitude(SrcB, Op == OP_SMUL);
                neg_reg <= (Op == OP_SMUL) && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
              end
            end
          end
        end
        S_RUN: begin
          if (!Flush) begin
            acc_reg <= acc_step;
            cnt_reg <= cnt_reg + CW'(1);
            opb_reg <= opb_reg >> 1;
            if (!is_div_reg) begin
              opa_reg <= opa_reg << 1;
            end
            if (last_iter) begin
              ResultLo <= result_next[WIDTH-1:0];
              ResultHi <= result_next[2*WIDTH-1:WIDTH];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Unused opcode localparams kept for readability of the decode
  logic unused_ops;
  assign unused_ops = ^{OP_MUL, OP_UMUL};

endmodule
